// File: rtl/eth_tx_frame_scheduler_if.sv
// eth_tx_frame_scheduler_if: request/grant and byte-stream bundle between three TX requesters and the MAC scheduler
interface eth_tx_frame_scheduler_if;
  logic [2:0]  i_req;
  logic [47:0] i_len;
  logic [47:0] i_type;
  logic [2:0]  o_grant;
  logic [23:0] i_data;
  logic [2:0]  i_valid;
  logic [2:0]  i_last;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_last;
  logic [15:0] o_len;
  logic [15:0] o_type;
  logic        o_busy;
  logic        o_err;
  modport master (
    output i_req, i_len, i_type, i_data, i_valid, i_last,
    input  o_grant, o_data, o_valid, o_last, o_len, o_type, o_busy, o_err
  );
  modport slave (
    input  i_req, i_len, i_type, i_data, i_valid, i_last,
    output o_grant, o_data, o_valid, o_last, o_len, o_type, o_busy, o_err
  );
endinterface

// File: rtl/eth_tx_frame_scheduler.sv
// eth_tx_frame_scheduler: whole-frame scheduler of ARP/ICMP/UDP requesters onto one MAC TX byte stream
module eth_tx_frame_scheduler #(
  parameter int P_IFG_CYCLES = 12,
  parameter int P_MAX_LEN    = 1500,
  parameter int P_START_TMO  = 64,
  parameter int P_STARVE_LIM = 4
) (
  input logic i_clk,
  input logic i_rst,
  eth_tx_frame_scheduler_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_ARB, S_GRANT, S_XFER, S_IFG} state_t;
  state_t      r_state, w_next;
  logic [1:0]  r_win, w_win;
  logic        r_rr;
  logic [7:0]  r_starve;
  logic [15:0] r_cnt, r_tick, w_cnt1, w_len, w_type;
  logic        r_bad, r_done, w_bad, w_any, w_v, w_l, w_fin, w_tmo, w_act;
  logic [7:0]  w_d;
  logic [2:0]  r_grant;
  logic [7:0]  r_data;
  logic        r_valid, r_last, r_err;
  logic [15:0] r_len, r_type;
  always_comb begin
    w_any  = |bus.i_req;
    w_win  = (bus.i_req[0] && !(r_starve == 8'(P_STARVE_LIM) && |bus.i_req[2:1])) ? 2'd0 :
             (bus.i_req[1] && bus.i_req[2]) ? (r_rr ? 2'd2 : 2'd1) :
             bus.i_req[1] ? 2'd1 : bus.i_req[2] ? 2'd2 : 2'd0;
    w_len  = bus.i_len[{w_win, 4'b0} +: 16];
    w_type = bus.i_type[{w_win, 4'b0} +: 16];
    w_bad  = w_len == 16'd0 || w_len > 16'(P_MAX_LEN);
    w_v    = bus.i_valid[r_win];
    w_l    = bus.i_last[r_win];
    w_d    = bus.i_data[{r_win, 3'b0} +: 8];
    w_cnt1 = r_cnt + 16'd1;
    w_act  = (r_state == S_GRANT || r_state == S_XFER) && w_v;
    w_fin  = w_act && w_l;
    w_tmo  = r_state == S_GRANT && !w_v && r_tick == 16'(P_START_TMO - 1);
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_any ? S_ARB : S_IDLE;
      S_ARB:   w_next = w_any ? S_GRANT : S_IDLE;
      S_GRANT: w_next = (w_fin || w_tmo) ? S_IFG : w_v ? S_XFER : S_GRANT;
      S_XFER:  w_next = w_fin ? S_IFG : S_XFER;
      S_IFG:   w_next = r_tick == 16'(P_IFG_CYCLES - 1) ? S_IDLE : S_IFG;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_win    <= '0;
      r_rr     <= 1'b0;
      r_starve <= '0;
      r_cnt    <= '0;
      r_tick   <= '0;
      r_bad    <= 1'b0;
      r_done   <= 1'b0;
      r_grant  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_err    <= 1'b0;
      r_len    <= '0;
      r_type   <= '0;
    end else begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_tick  <= (w_next != r_state) ? 16'd0 : r_tick + 16'd1;
      if (r_state == S_ARB && w_any) begin
        r_win   <= w_win;
        r_len   <= w_len;
        r_type  <= w_type;
        r_bad   <= w_bad;
        r_err   <= w_bad;
        r_grant <= 3'b001 << w_win;
        r_cnt   <= '0;
        r_done  <= 1'b0;
        // rr pointer: 0 favours port 1, 1 favours port 2
        if (w_win == 2'd0) begin
          if (|bus.i_req[2:1]) r_starve <= r_starve + 8'd1;
        end else begin
          r_starve <= '0;
          r_rr     <= w_win == 2'd1;
        end
      end
      if (w_act) begin
        r_cnt  <= w_cnt1;
        r_data <= w_d;
        if (!r_done) begin
          r_valid <= !r_bad;
          r_last  <= !r_bad && (w_l || w_cnt1 == r_len);
          r_done  <= w_cnt1 == r_len;
        end
        if (w_l) begin
          r_grant <= '0;
          r_err   <= !r_bad && w_cnt1 != r_len;
        end
      end
      if (w_tmo) begin
        r_grant <= '0;
        r_err   <= 1'b1;
      end
    end
  end
  assign bus.o_grant = r_grant;
  assign bus.o_data  = r_data;
  assign bus.o_valid = r_valid;
  assign bus.o_last  = r_last;
  assign bus.o_len   = r_len;
  assign bus.o_type  = r_type;
  assign bus.o_err   = r_err;
  assign bus.o_busy  = r_state != S_IDLE;
endmodule

// File: tb/tb_eth_tx_frame_scheduler.sv
// tb_eth_tx_frame_scheduler: directed frame scenarios with requester model and output monitor
module tb_eth_tx_frame_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b1;
  always #5 clk = ~clk;
  eth_tx_frame_scheduler_if bus ();
  eth_tx_frame_scheduler dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  int want[3] = '{0, 0, 0};
  int nb[3] = '{0, 0, 0};
  logic [15:0] lenv[3] = '{16'd0, 16'd0, 16'd0};
  logic [15:0] typv[3] = '{16'h0806, 16'h0801, 16'h0800};
  logic [2:0] req = '0, val = '0, lst = '0, gprev = '0;
  logic [7:0] dat[3] = '{8'd0, 8'd0, 8'd0};
  int sent[3] = '{0, 0, 0};
  int got[3] = '{0, 0, 0};
  assign bus.i_req   = req;
  assign bus.i_valid = val;
  assign bus.i_last  = lst;
  assign bus.i_data  = {dat[2], dat[1], dat[0]};
  assign bus.i_len   = {lenv[2], lenv[1], lenv[0]};
  assign bus.i_type  = {typv[2], typv[1], typv[0]};
  // requester model: holds req until granted, then streams bytes 1..nb with i_last on byte nb
  always @(negedge clk) begin
    for (int p = 0; p < 3; p++) begin
      if (clr) begin
        got[p] = 0;
        gprev[p] = 1'b0;
      end else if (rst) begin
        if (gprev[p]) got[p]--;
        gprev[p] = 1'b0;
      end else begin
        if (bus.o_grant[p] && !gprev[p]) begin
          got[p]++;
          sent[p] = 0;
        end
        gprev[p] = bus.o_grant[p];
      end
      val[p] = 1'b0;
      lst[p] = 1'b0;
      if (!rst && !clr && bus.o_grant[p] && sent[p] < nb[p]) begin
        sent[p]++;
        val[p] = 1'b1;
        dat[p] = 8'(sent[p]);
        lst[p] = sent[p] == nb[p];
      end
      req[p] = !rst && !clr && !bus.o_grant[p] && got[p] < want[p];
    end
  end
  int cyc = 0, nvalid, nlast, nerr, data_bad, gcyc, last_cyc, min_gap, fbytes, ngr, gseq;
  int fl[$];
  logic [15:0] tl[$], ll[$];
  logic [2:0] gmon_prev;
  always @(negedge clk) begin
    cyc++;
    if (clr) begin
      nvalid = 0; nlast = 0; nerr = 0; data_bad = 0; gcyc = 0; ngr = 0; gseq = 0;
      last_cyc = -1; min_gap = 1000000; fbytes = 0; gmon_prev = '0;
      fl.delete(); tl.delete(); ll.delete();
    end else begin
      if (rst) fbytes = 0;
      if (bus.o_valid) begin
        nvalid++;
        fbytes++;
        if (bus.o_data !== 8'(fbytes)) data_bad++;
      end
      if (bus.o_last) begin
        fl.push_back(fbytes);
        fbytes = 0;
        nlast++;
        last_cyc = cyc;
      end
      if (bus.o_err) nerr++;
      if (|bus.o_grant) gcyc++;
      if (bus.o_grant != 3'b0 && gmon_prev == 3'b0) begin
        ngr++;
        gseq = gseq * 16 + (bus.o_grant[0] ? 1 : bus.o_grant[1] ? 2 : 3);
        tl.push_back(bus.o_type);
        ll.push_back(bus.o_len);
        if (last_cyc >= 0 && cyc - last_cyc < min_gap) min_gap = cyc - last_cyc;
      end
      gmon_prev = bus.o_grant;
    end
  end
  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic hold();
    @(posedge clk);
    #2 rst = 1'b1;
    clr = 1'b1;
  endtask
  task automatic go();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    clr = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int n, input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      @(posedge clk);
      #2;
      if (ngr >= n && !bus.o_busy && bus.i_req == 3'b0) break;
    end
    chk(tag, longint'(i < maxc), 1);
  endtask
  initial begin
    @(negedge clk);
    chk("reset_outputs", {bus.o_grant, bus.o_data, bus.o_valid, bus.o_last, bus.o_len, bus.o_type, bus.o_busy, bus.o_err}, 0);
    go();
    repeat (3) @(posedge clk);
    chk("idle_not_busy", bus.o_busy, 0);
    hold();
    want = '{1, 0, 1}; nb = '{60, 0, 60}; lenv = '{16'd60, 16'd0, 16'd60};
    go();
    wait_done("t1_done", 2, 1000);
    chk("t1_order", gseq, 'h13);
    chk("t1_type_p0", tl[0], 16'h0806);
    chk("t1_type_p2", tl[1], 16'h0800);
    chk("t1_len", ll[1], 60);
    chk("t1_ifg", longint'(min_gap >= 13), 1);
    chk("t1_bytes", nvalid, 120);
    chk("t1_frame_len", fl[1], 60);
    chk("t1_err", nerr, 0);
    hold();
    want = '{0, 2, 2}; nb = '{0, 64, 64}; lenv = '{16'd0, 16'd64, 16'd64};
    go();
    wait_done("t2_done", 4, 2000);
    chk("t2_rr_order", gseq, 'h2323);
    chk("t2_lasts", nlast, 4);
    chk("t2_f0", fl[0], 64);
    chk("t2_f3", fl[3], 64);
    chk("t2_bytes", nvalid, 256);
    chk("t2_data", data_bad, 0);
    hold();
    want = '{6, 0, 1}; nb = '{20, 0, 20}; lenv = '{16'd20, 16'd0, 16'd20};
    go();
    wait_done("t3_done", 7, 3000);
    chk("t3_starve_order", gseq, 'h1111311);
    chk("t3_err", nerr, 0);
    hold();
    want = '{0, 1, 0}; nb = '{0, 80, 0}; lenv = '{16'd0, 16'd100, 16'd0};
    go();
    wait_done("t4a_done", 1, 1000);
    chk("t4a_last_at", fl[0], 80);
    chk("t4a_err", nerr, 1);
    chk("t4a_lasts", nlast, 1);
    hold();
    nb = '{0, 120, 0};
    go();
    wait_done("t4b_done", 1, 1000);
    chk("t4b_last_at", fl[0], 100);
    chk("t4b_dropped", nvalid, 100);
    chk("t4b_err", nerr, 1);
    chk("t4b_data", data_bad, 0);
    hold();
    want = '{0, 0, 1}; nb = '{0, 0, 10}; lenv = '{16'd0, 16'd0, 16'd0};
    go();
    wait_done("t5a_done", 1, 1000);
    chk("t5a_err", nerr, 1);
    chk("t5a_no_valid", nvalid, 0);
    chk("t5a_no_last", nlast, 0);
    hold();
    nb = '{0, 0, 0}; lenv = '{16'd0, 16'd0, 16'd20};
    go();
    wait_done("t5b_done", 1, 1000);
    chk("t5b_err", nerr, 1);
    chk("t5b_grant_cycles", gcyc, 64);
    chk("t5b_no_valid", nvalid, 0);
    hold();
    want = '{0, 1, 1}; nb = '{0, 60, 60}; lenv = '{16'd0, 16'd60, 16'd60};
    go();
    begin
      int i;
      for (i = 0; i < 500 && nvalid < 10; i++) @(posedge clk);
      chk("t6_reach_xfer", longint'(i < 500), 1);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("t6_reset_outputs", {bus.o_grant, bus.o_data, bus.o_valid, bus.o_last, bus.o_len, bus.o_type, bus.o_busy, bus.o_err}, 0);
    chk("t6_no_last", nlast, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wait_done("t6_done", 3, 1500);
    chk("t6_rearb_order", gseq, 'h223);
    chk("t6_lasts", nlast, 2);
    chk("t6_data", data_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
